// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
`timescale 1ns/1ps
package serial_sub_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } serial_sub_state_t;

    // Counter must hold the value WIDTH after the last increment, so one bit above $clog2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bi, bo = borrow out.
`timescale 1ns/1ps
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
`timescale 1ns/1ps
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    serial_sub_state_t state_reg;
    logic [WIDTH-1:0]  a_sh_reg;
    logic [WIDTH-1:0]  b_sh_reg;
    logic [WIDTH-1:0]  res_reg;
    logic [WIDTH-1:0]  res_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              brw_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [WIDTH-1:0]  diff_reg;
    logic              bout_reg;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_reg;
`endif

    logic cell_d;
    logic cell_bo;

    full_subtractor_cell u_cell (
        .x  (a_sh_reg[0]),
        .y  (b_sh_reg[0]),
        .bi (brw_reg),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // New result bit enters at the MSB so the word is aligned after WIDTH shifts.
    always_comb begin
        res_next            = res_reg >> 1;
        res_next[WIDTH-1]   = cell_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            brw_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        brw_reg   <= bin;
                        cnt_reg   <= '0;
                        res_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    brw_reg  <= cell_bo;
                    cnt_reg  <= cnt_reg + 1'b1;
                    res_reg  <= res_next;
                    if (cnt_reg == LAST) begin
                        // Publish all results together; brw_reg is the borrow into the MSB here.
                        diff_reg  <= res_next;
                        bout_reg  <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_reg   <= brw_reg ^ cell_bo;
`endif
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule
